// File: rtl/gray_bin_conv_pipe.sv
// Pipelined bidirectional Gray<->binary converter with valid/ready handshake.
// Gray->binary is resolved MSB-first across the stages; binary->Gray finishes in stage 0.
module gray_bin_conv_pipe #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic             busy
);

    localparam int PER = (WIDTH + STAGES - 1) / STAGES;

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES-1:0] mode_q, mode_d;
    logic [STAGES-1:0] adv;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  data_q [STAGES];
    logic [WIDTH-1:0]  data_d [STAGES];

    // A Gray word in flight keeps its unresolved low bits as the original Gray bits,
    // so the stage word always carries the full information of the original input.
    function automatic logic [WIDTH-1:0] resolve_stage(input logic [WIDTH-1:0] word,
                                                       input int stage);
        logic [WIDTH-1:0] r;
        logic             carry;
        int               hi;
        int               lo;
        r     = word;
        carry = 1'b0;
        hi    = WIDTH - 1 - stage * PER;
        lo    = WIDTH - (stage + 1) * PER;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (i <= hi && i >= lo) begin
                r[i] = carry ^ r[i];
            end
            carry = r[i];
        end
        return r;
    endfunction

    always_comb begin
        adv      = '0;
        load     = '0;
        v_d      = v_q;
        mode_d   = mode_q;
        in_ready = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            data_d[k] = data_q[k];
        end

        // Advance chain runs from the output back so a consumed word frees the whole pipe.
        adv[STAGES-1] = v_q[STAGES-1] & out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = v_q[k] & (~v_q[k+1] | adv[k+1]);
        end
        in_ready = ~v_q[0] | adv[0];

        load[0] = in_valid & in_ready;
        for (int k = 1; k < STAGES; k++) begin
            load[k] = adv[k-1];
        end

        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = load[k] | (v_q[k] & ~adv[k]);
        end

        if (load[0]) begin
            mode_d[0] = in_mode;
            data_d[0] = in_mode ? (in_data ^ (in_data >> 1)) : resolve_stage(in_data, 0);
        end
        for (int k = 1; k < STAGES; k++) begin
            if (load[k]) begin
                mode_d[k] = mode_q[k-1];
                data_d[k] = mode_q[k-1] ? data_q[k-1] : resolve_stage(data_q[k-1], k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            mode_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            v_q    <= v_d;
            mode_q <= mode_d;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_data  = data_q[STAGES-1];
    assign out_mode  = mode_q[STAGES-1];
    assign busy      = |v_q;

endmodule
